// File: rtl/in_unit_fifo_route_if.sv
// Router input-port link bundle.
// Groups the upstream valid/full link, the allocator request/grant side and the
// occupancy status of one input unit.
//   master : the environment (upstream router output + switch allocator)
//   slave  : the input unit itself
// Signals:
//   in_data/in_valid  flit from upstream (held stable while full=1)
//   full              backpressure to upstream
//   req_valid/req_dir head flit present and its one-hot route {local,y,x2,x1}
//   head_data         head flit to crossbar
//   grant             allocator grant, pops the head
//   count             occupancy 0..DEPTH
interface in_unit_fifo_route_if #(
  parameter int DATA_WIDTH = 32,
  parameter int PTR_W      = 2
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  full;
  logic                  req_valid;
  logic [3:0]            req_dir;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  grant;
  logic [PTR_W:0]        count;

  modport master (
    output in_data, in_valid, grant,
    input  full, req_valid, req_dir, head_data, count
  );

  modport slave (
    input  in_data, in_valid, grant,
    output full, req_valid, req_dir, head_data, count
  );
endinterface

// File: rtl/in_unit_fifo_route.sv
// Router input-port stage: DEPTH-entry FIFO on a valid/full link with XY route
// computation on the head flit.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : in_unit_fifo_route_if.slave (link, request/grant, count)
// Header fields: dest_x = flit[DATA_WIDTH-1:DATA_WIDTH-2], dest_y = flit[DATA_WIDTH-3].
module in_unit_fifo_route #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int PTR_W      = 2,
  parameter int X_ID       = 0,
  parameter int Y_ID       = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  in_unit_fifo_route_if.slave     bus
);

  localparam logic [1:0]     MY_X    = 2'(X_ID);
  localparam logic           MY_Y    = 1'(Y_ID);
  localparam logic [PTR_W:0] CNT_MAX = (PTR_W+1)'(DEPTH);

  localparam logic [3:0] DIR_X1    = 4'b0001;
  localparam logic [3:0] DIR_X2    = 4'b0010;
  localparam logic [3:0] DIR_Y     = 4'b0100;
  localparam logic [3:0] DIR_LOCAL = 4'b1000;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W:0]        count;

  logic                  full;
  logic                  not_empty;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] head;
  logic [1:0]            dest_x;
  logic                  dest_y;
  logic [3:0]            dir;

  // full depends only on the registered count, so a pop never frees a slot
  // for a push in the same cycle.
  assign full      = (count == CNT_MAX);
  assign not_empty = (count != '0);
  assign push      = bus.in_valid & ~full;
  assign pop       = bus.grant & not_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Storage is intentionally left unreset; the empty-gate on head hides it.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_data;
  end

  assign head   = not_empty ? mem[rd_ptr] : '0;
  assign dest_x = head[DATA_WIDTH-1 -: 2];
  assign dest_y = head[DATA_WIDTH-3];

  always_comb begin
    dir = 4'b0000;
    if (not_empty) begin
      if (dest_x < MY_X)      dir = DIR_X1;
      else if (dest_x > MY_X) dir = DIR_X2;
      else if (dest_y != MY_Y) dir = DIR_Y;
      else                    dir = DIR_LOCAL;
    end
  end

  assign bus.full      = full;
  assign bus.req_valid = not_empty;
  assign bus.req_dir   = dir;
  assign bus.head_data = head;
  assign bus.count     = count;

endmodule
